// File: rtl/four_bit_adder_pkg.sv
// Shared width constant and nibble type for the registered 4-bit adder.
package four_bit_adder_pkg;
   localparam int unsigned ADDER_WIDTH = 4;
   typedef logic [ADDER_WIDTH-1:0] nibble_t;
endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; chained by four_bit_adder into a ripple-carry adder.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/four_bit_adder.sv
// Registered ripple-carry adder with carry, signed-overflow and zero flags, 1-cycle latency.
// Optional unsigned saturation on carry-out when FOUR_BIT_ADDER_SAT_EN is defined.
module four_bit_adder
   import four_bit_adder_pkg::*;
#(
   parameter int unsigned WIDTH = ADDER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             out_valid
);
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] raw_sum;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic             cout_d, cout_q;
   logic             ovf_d, ovf_q;
   logic             zero_d, zero_q;
   logic             valid_q;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
      full_adder_cell u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (carry[i]),
         .s  (raw_sum[i]),
         .co (carry[i+1])
      );
   end

   always_comb begin
      sum_d  = raw_sum;
`ifdef FOUR_BIT_ADDER_SAT_EN
      if (carry[WIDTH]) begin
         sum_d = '1;
      end
`endif
      cout_d = carry[WIDTH];
      // Signed overflow is a property of the true add, so it uses the unsaturated sum.
      ovf_d  = (a[WIDTH-1] == b[WIDTH-1]) && (raw_sum[WIDTH-1] != a[WIDTH-1]);
      zero_d = (sum_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
         end
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign out_valid = valid_q;
endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder against an integer-arithmetic reference model.
module tb_four_bit_adder;
   import four_bit_adder_pkg::*;

`ifdef FOUR_BIT_ADDER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic    clk = 1'b0;
   logic    rst, in_valid, cin;
   nibble_t a, b;
   nibble_t sum;
   logic    cout, overflow, zero, out_valid;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   nibble_t m_sum;
   bit      m_cout, m_ovf, m_zero, m_valid;

   four_bit_adder #(.WIDTH(ADDER_WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow),
      .zero      (zero),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] obs_vec();
      return {out_valid, sum, cout, overflow, zero};
   endfunction

   function automatic logic [7:0] exp_vec();
      return {m_valid, m_sum, m_cout, m_ovf, m_zero};
   endfunction

   // Drive one cycle, advance the model on the same edge, then sample 1 time unit later.
   task automatic drive(input bit r, input bit v, input nibble_t x, input nibble_t y,
                        input bit c);
      int full, sx, sy, sres;
      rst = r; in_valid = v; a = x; b = y; cin = c;
      @(posedge clk);
      if (r) begin
         m_sum = '0; m_cout = 0; m_ovf = 0; m_zero = 0; m_valid = 0;
      end else begin
         m_valid = v;
         if (v) begin
            full   = int'(x) + int'(y) + int'(c);
            m_cout = (full > 15);
            m_sum  = (SAT && full > 15) ? nibble_t'(15) : nibble_t'(full % 16);
            sx     = (x >= 8) ? int'(x) - 16 : int'(x);
            sy     = (y >= 8) ? int'(y) - 16 : int'(y);
            sres   = sx + sy + int'(c);
            m_ovf  = (sres > 7) || (sres < -8);
            m_zero = (m_sum == 0);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1, 1, 4'd5, 4'd5, 0);
         checks++;
         if (obs_vec() !== 8'h00) begin
            failures++;
            $display("FAIL reset_cycle%0d got=%h want=00", i, obs_vec());
         end
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 4'd5, 4'd5, 0);
         checks++;
         if (obs_vec() !== exp_vec() || obs_vec() !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold%0d got=%h want=00", i, obs_vec());
         end
      end
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            drive(0, 1, nibble_t'(i), nibble_t'(j), 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
               failures++;
               $display("FAIL sweep a=%0d b=%0d got=%h want=%h", i, j, obs_vec(), exp_vec());
            end
            if (i == 7 && j == 7) begin
               checks++;
               if (sum !== 4'd14 || overflow !== 1'b1 || zero !== 1'b0 || cout !== 1'b0) begin
                  failures++;
                  $display("FAIL sweep_7p7 sum=%0d ovf=%b zero=%b cout=%b want 14/1/0/0",
                           sum, overflow, zero, cout);
               end
            end
         end
      end
   endtask

   task automatic test_wrap();
      drive(0, 1, 4'd15, 4'd1, 0);
      checks++;
      if (sum !== (SAT ? 4'd15 : 4'd0) || cout !== 1'b1 || zero !== !SAT || overflow !== 1'b0)
      begin
         failures++;
         $display("FAIL wrap sum=%0d cout=%b zero=%b ovf=%b", sum, cout, zero, overflow);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL wrap_model got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_carry_ovf();
      drive(0, 1, 4'd7, 4'd0, 1);
      checks++;
      if (sum !== 4'd8 || overflow !== 1'b1 || cout !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL cin_ovf sum=%0d ovf=%b cout=%b want 8/1/0", sum, overflow, cout);
      end
      drive(0, 1, 4'd8, 4'd8, 0);
      checks++;
      if (sum !== (SAT ? 4'd15 : 4'd0) || cout !== 1'b1 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL neg_ovf sum=%0d cout=%b ovf=%b", sum, cout, overflow);
      end
   endtask

   task automatic test_valid_gating();
      drive(0, 1, 4'd3, 4'd4, 0);
      checks++;
      if (out_valid !== 1'b1 || sum !== 4'd7) begin
         failures++;
         $display("FAIL gate_first valid=%b sum=%0d want 1/7", out_valid, sum);
      end
      drive(0, 0, 4'd9, 4'd9, 1);
      checks++;
      if (out_valid !== 1'b0 || sum !== 4'd7 || obs_vec() !== exp_vec()) begin
         failures++;
         $display("FAIL gate_hold valid=%b sum=%0d want 0/7", out_valid, sum);
      end
      drive(0, 1, 4'd2, 4'd2, 0);
      checks++;
      if (out_valid !== 1'b1 || sum !== 4'd4) begin
         failures++;
         $display("FAIL gate_second valid=%b sum=%0d want 1/4", out_valid, sum);
      end
   endtask

   task automatic test_reset_mid();
      drive(0, 1, 4'd9, 4'd3, 0);
      checks++;
      if (out_valid !== 1'b1 || sum !== 4'd12) begin
         failures++;
         $display("FAIL mid_pre valid=%b sum=%0d want 1/12", out_valid, sum);
      end
      drive(1, 1, 4'd1, 4'd1, 0);
      checks++;
      if (obs_vec() !== 8'h00) begin
         failures++;
         $display("FAIL mid_rst got=%h want=00", obs_vec());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
               nibble_t'($urandom), nibble_t'($urandom), 1'($urandom));
         checks++;
         if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
      test_reset();
      test_sweep();
      test_wrap();
      test_carry_ovf();
      test_valid_gating();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/four_bit_adder.md
Name: four_bit_adder

Overview:
Registered 4-bit binary adder with carry-in, carry-out and status flags. Operands are sampled on a valid strobe and the result is presented one clock later. Used as a small arithmetic leaf in datapaths needing a fixed-latency unsigned/two's-complement add of nibble-wide operands.

Parameters:
WIDTH, 4, operand and sum width in bits; only 4 is verified, and the RTL must stay generic in WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands valid this cycle
a  input  WIDTH  operand A (unsigned, or two's complement for the overflow flag)
b  input  WIDTH  operand B
cin  input  1  carry-in
sum  output  WIDTH  registered sum, modulo 2^WIDTH
cout  output  1  registered carry-out, bit WIDTH of a+b+cin
overflow  output  1  registered signed overflow flag
zero  output  1  registered flag, high when sum == 0
out_valid  output  1  result valid

Behaviour:
- Single clock domain. All outputs are registered and update on the rising edge of clk.
- Reset: when rst=1 at a clock edge, sum=0, cout=0, overflow=0, zero=0, out_valid=0. Reset takes priority over in_valid.
- Latency: exactly 1 cycle. If in_valid=1 at edge N, then the result of that sample is on the outputs after edge N, and out_valid=1 during cycle N+1.
- When in_valid=0 at an edge, out_valid goes to 0. sum, cout, overflow and zero hold their previous values.
- No backpressure and no ready signal. A new operand pair may be accepted every cycle (throughput 1/cycle).
- Arithmetic: full = a + b + cin, computed as WIDTH+1 bits.
  - sum = full[WIDTH-1:0], wrapping modulo 2^WIDTH (e.g. 15+1+0 gives sum=0, cout=1).
  - cout = full[WIDTH].
  - overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
  - zero = (sum==0), evaluated on the post-feature sum.
- Carry chain is a ripple of full-adder cells: cin feeds bit 0, and each bit's carry feeds the next bit.
- Reset asserted while a result is pending drops that result: out_valid=0 on the next cycle.
- If rst and in_valid are asserted together, the operands are discarded.

Optional Feature:
Macro FOUR_BIT_ADDER_SAT_EN.
- Defined: unsigned saturation. When cout=1, sum is forced to all ones (15). cout still reports the true carry, and zero is computed on the saturated sum.
- Undefined: sum wraps modulo 2^WIDTH as described above.

Decomposition:
- Shared package four_bit_adder_pkg holds the constant ADDER_WIDTH=4 and the typedef nibble_t (logic [3:0]).
- One sub-module, full_adder_cell (inputs a, b, ci; outputs s, co; s = a^b^ci, co = majority), instantiated WIDTH times in a generate loop.
- The top level holds the input-to-register datapath, the flag logic, the optional saturation logic and the valid pipeline bit.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=5, b=5 -> all outputs are 0 and out_valid=0; after rst is released the outputs hold until the next valid input.
- Exhaustive sweep: a=0..7, b=0..7, cin=0, in_valid=1 every cycle -> each following cycle sum=a+b and cout=0; for example a=7, b=7 gives sum=14, overflow=1, zero=0.
- Wrap and carry: a=15, b=1, cin=0 -> sum=0, cout=1, zero=1, overflow=0. With FOUR_BIT_ADDER_SAT_EN defined -> sum=15, cout=1, zero=0.
- Carry-in and signed overflow: a=7, b=0, cin=1 -> sum=8, overflow=1. Then a=8, b=8, cin=0 -> sum=0, cout=1, overflow=1.
- Valid gating: in_valid pattern 1,0,1 with a=3, b=4 then a=2, b=2 -> out_valid pattern 1,0,1, with sum=7, then 7 held, then 4.
- Reset mid-operation: in_valid=1 (a=9, b=3) at edge N and rst=1 at edge N+1 -> out_valid=1 with sum=12 after edge N, then all outputs 0 after edge N+1.
